// File: rtl/phase_rx_ctrl.sv
// phase_rx_ctrl: BPSK receive-side byte assembler.
// Samples the demodulated phase bit once per baud period at mid-bit and
// assembles bytes MSB first. Each completed byte is written to a BRAM at
// consecutive addresses starting from 0. After frame_length bytes, the block
// pulses frame_done.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   rx_en             demodulator carrier-present gate; a low->high edge starts a frame
//   phase_bit         demodulated hard bit, synchronous to clk
//   ram_*             BRAM write port (ram_clk = clk, ram_rst tied low)
//   byte_count        bytes written in the current or last frame
//   busy              high while a frame is being received
//   frame_done        one-cycle pulse when a frame completes
//   frame_err         one-cycle pulse when a frame is aborted by rx_en dropping
//
// state  | meaning
// S_IDLE | waiting for a rising edge on rx_en
// S_HALF | counting half a bit period to reach the middle of bit 0
// S_BIT  | sampling once per bit period; issues byte writes
// S_DONE | one cycle; pulses frame_done
module phase_rx_ctrl #(
   parameter int data_width   = 8,
   parameter int frame_length = 150,
   parameter int addr_width   = 8,
   parameter int ref_clk_freq = 100000000,
   parameter int baudrate     = 9600
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_en,
   input  logic                  phase_bit,
   output logic                  ram_clk,
   output logic                  ram_rst,
   output logic                  ram_en,
   output logic [0:0]            ram_we,
   output logic [addr_width-1:0] ram_addr,
   output logic [data_width-1:0] ram_wr_data,
   output logic [addr_width-1:0] byte_count,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  frame_err
);

   localparam int cycle = ref_clk_freq / baudrate;
   localparam int half  = cycle / 2;
   localparam int bw    = (data_width > 1) ? $clog2(data_width) : 1;

   localparam logic [15:0]           cycle_last = 16'(cycle - 1);
   localparam logic [15:0]           half_last  = 16'(half - 1);
   localparam logic [bw-1:0]         bit_last   = bw'(data_width - 1);
   localparam logic [addr_width-1:0] last_byte  = addr_width'(frame_length - 1);

   typedef enum logic [1:0] {S_IDLE, S_HALF, S_BIT, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [15:0]           cycle_cnt_q, cycle_cnt_d;
   logic [bw-1:0]         bit_cnt_q, bit_cnt_d;
   logic [addr_width-1:0] byte_count_q, byte_count_d;
   logic [data_width-1:0] shift_q, shift_d;
   logic                  rx_en_d_q, rx_en_d_d;
   logic                  wr_pend_q, wr_pend_d;
   logic                  abort_q, abort_d;
   logic                  ram_en_q, ram_en_d;
   logic [addr_width-1:0] ram_addr_q, ram_addr_d;
   logic [data_width-1:0] ram_wr_data_q, ram_wr_data_d;
   logic                  frame_done_q, frame_done_d;
   logic                  frame_err_q, frame_err_d;
   logic                  sample;

   always_comb begin
      state_d       = state_q;
      cycle_cnt_d   = cycle_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      byte_count_d  = byte_count_q;
      shift_d       = shift_q;
      rx_en_d_d     = rx_en;
      wr_pend_d     = 1'b0;
      abort_d       = 1'b0;
      ram_en_d      = 1'b0;
      ram_addr_d    = ram_addr_q;
      ram_wr_data_d = ram_wr_data_q;
      frame_done_d  = 1'b0;
      frame_err_d   = abort_q;
      sample        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rx_en && !rx_en_d_q) begin
               state_d      = S_HALF;
               cycle_cnt_d  = '0;
               bit_cnt_d    = '0;
               byte_count_d = '0;
               shift_d      = '0;
            end
         end
         S_HALF: begin
            if (!rx_en) begin
               state_d = S_IDLE;
               abort_d = 1'b1;
            end else if (cycle_cnt_q == half_last) begin
               sample      = 1'b1;
               cycle_cnt_d = '0;
               state_d     = S_BIT;
            end else begin
               cycle_cnt_d = cycle_cnt_q + 16'd1;
            end
         end
         S_BIT: begin
            // an abort also drops a write still pending from the last sample
            if (!rx_en) begin
               state_d = S_IDLE;
               abort_d = 1'b1;
            end else begin
               if (cycle_cnt_q == cycle_last) begin
                  sample      = 1'b1;
                  cycle_cnt_d = '0;
               end else begin
                  cycle_cnt_d = cycle_cnt_q + 16'd1;
               end
               if (wr_pend_q) begin
                  ram_en_d      = 1'b1;
                  ram_addr_d    = byte_count_q;
                  ram_wr_data_d = shift_q;
                  byte_count_d  = byte_count_q + 1'b1;
                  if (byte_count_q == last_byte) state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (sample) begin
         shift_d   = {shift_q[data_width-2:0], phase_bit};
         wr_pend_d = (bit_cnt_q == bit_last);
         bit_cnt_d = (bit_cnt_q == bit_last) ? '0 : bit_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cycle_cnt_q   <= '0;
         bit_cnt_q     <= '0;
         byte_count_q  <= '0;
         shift_q       <= '0;
         rx_en_d_q     <= 1'b1;
         wr_pend_q     <= 1'b0;
         abort_q       <= 1'b0;
         ram_en_q      <= 1'b0;
         ram_addr_q    <= '0;
         ram_wr_data_q <= '0;
         frame_done_q  <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cycle_cnt_q   <= cycle_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         byte_count_q  <= byte_count_d;
         shift_q       <= shift_d;
         rx_en_d_q     <= rx_en_d_d;
         wr_pend_q     <= wr_pend_d;
         abort_q       <= abort_d;
         ram_en_q      <= ram_en_d;
         ram_addr_q    <= ram_addr_d;
         ram_wr_data_q <= ram_wr_data_d;
         frame_done_q  <= frame_done_d;
         frame_err_q   <= frame_err_d;
      end
   end

   assign ram_clk     = clk;
   assign ram_rst     = 1'b0;
   assign ram_en      = ram_en_q;
   assign ram_we      = ram_en_q;
   assign ram_addr    = ram_addr_q;
   assign ram_wr_data = ram_wr_data_q;
   assign byte_count  = byte_count_q;
   assign busy        = (state_q == S_HALF) || (state_q == S_BIT);
   assign frame_done  = frame_done_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_phase_rx_ctrl.sv
// Bench for phase_rx_ctrl with CYCLE=10, HALF=5, frame_length=2.
module tb_phase_rx_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_en = 1'b1;
   logic       phase_bit = 1'b0;
   logic       ram_clk, ram_rst, ram_en;
   logic [0:0] ram_we;
   logic [7:0] ram_addr, ram_wr_data, byte_count;
   logic       busy, frame_done, frame_err;

   phase_rx_ctrl #(
      .data_width(8), .frame_length(2), .addr_width(8),
      .ref_clk_freq(100), .baudrate(10)
   ) dut (
      .clk(clk), .rst(rst), .rx_en(rx_en), .phase_bit(phase_bit),
      .ram_clk(ram_clk), .ram_rst(ram_rst), .ram_en(ram_en), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .byte_count(byte_count),
      .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int       cyc;
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t exp_wr[$];
   int  exp_done[$];
   int  exp_err[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   int  edge_n  = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
                  tag, got, got, exp, exp, edge_n);
      end
   endtask

   // output monitor: compares DUT writes and pulses against the scoreboard
   always @(posedge clk) begin
      wr_t w;
      int  c;
      edge_n = edge_n + 1;
      #1;
      if (ram_en === 1'b1) begin
         if (exp_wr.size() == 0) chk("wr_unexpected", int'(ram_addr), -1);
         else begin
            w = exp_wr.pop_front();
            chk("wr_cycle", edge_n, w.cyc);
            chk("wr_addr", int'(ram_addr), int'(w.addr));
            chk("wr_data", int'(ram_wr_data), int'(w.data));
            chk("wr_we", int'(ram_we), 1);
         end
      end
      if (frame_done === 1'b1) begin
         if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
         else begin
            c = exp_done.pop_front();
            chk("done_cycle", edge_n, c);
         end
      end
      if (frame_err === 1'b1) begin
         if (exp_err.size() == 0) chk("err_unexpected", 1, 0);
         else begin
            c = exp_err.pop_front();
            chk("err_cycle", edge_n, c);
         end
      end
   end

   // Drives one frame of two bytes. rx_en is pulled low for one cycle first,
   // then raised; cycle 0 is the first edge that sees it high.
   task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input bit glitch, input int abort_at, input int rst_at);
      logic [15:0] bits;
      int t0, bi;
      logic pb;
      bits = {b0, b1};
      rst = 1'b0;
      rx_en = 1'b0;
      @(negedge clk);
      t0 = 0;
      for (int c = 0; c <= 170; c++) begin
         if (c == 0) begin
            t0 = edge_n + 1;
            exp_wr.push_back('{t0 + 76, 8'd0, b0});
            if (abort_at < 0 && rst_at < 0) begin
               exp_wr.push_back('{t0 + 156, 8'd1, b1});
               exp_done.push_back(t0 + 157);
            end
            if (abort_at >= 0) exp_err.push_back(t0 + abort_at + 1);
         end
         rx_en = (abort_at < 0) || (c < abort_at);
         rst   = (c == rst_at);
         bi = c / 10;
         pb = (bi < 16) ? bits[15 - bi] : 1'b0;
         if (glitch && ((c % 10) == 0 || (c % 10) == 9)) pb = ~pb;
         phase_bit = pb;
         if (c == 1) begin
            chk("start_byte_count", int'(byte_count), 0);
            chk("start_busy", int'(busy), 1);
         end
         @(negedge clk);
      end
      rst = 1'b0;
      chk("end_busy", int'(busy), 0);
      if (abort_at >= 0)    chk("abort_byte_count", int'(byte_count), 1);
      else if (rst_at >= 0) chk("rst_byte_count", int'(byte_count), 0);
      else                  chk("frame_byte_count", int'(byte_count), 2);
   endtask

   initial begin
      // reset held with rx_en high
      repeat (3) @(negedge clk);
      chk("rst_ram_en", int'(ram_en), 0);
      chk("rst_ram_we", int'(ram_we), 0);
      chk("rst_ram_addr", int'(ram_addr), 0);
      chk("rst_ram_data", int'(ram_wr_data), 0);
      chk("rst_byte_count", int'(byte_count), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(frame_done), 0);
      chk("rst_err", int'(frame_err), 0);
      chk("rst_ram_rst", int'(ram_rst), 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("no_start_busy", int'(busy), 0);

      // nominal and glitched frames
      run_frame(8'hA5, 8'h3C, 1'b0, -1, -1);
      run_frame(8'hA5, 8'h3C, 1'b1, -1, -1);

      // rx_en held high after done: no new frame
      repeat (30) @(negedge clk);
      chk("hold_busy", int'(busy), 0);
      chk("hold_byte_count", int'(byte_count), 2);

      // restart with different data
      run_frame(8'h5A, 8'hC3, 1'b0, -1, -1);

      // abort at cycle 100
      run_frame(8'hA5, 8'h3C, 1'b0, 100, -1);

      // reset at cycle 80, then a clean frame
      run_frame(8'hA5, 8'h3C, 1'b0, -1, 80);
      run_frame(8'hF0, 8'h0F, 1'b1, -1, -1);

      repeat (20) @(negedge clk);
      chk("sb_wr_left", exp_wr.size(), 0);
      chk("sb_done_left", exp_done.size(), 0);
      chk("sb_err_left", exp_err.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
